// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle for one pipeline stage: upstream (in_*) and downstream (out_*) sides.
// The master modport is the environment around the stage. The slave modport is the stage itself.
interface pipe_stage_skid_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer, flush, and saturating stall/flush counters.
// in_ready and out_valid decode from the state register only, so no combinational ready path exists.
module pipe_stage_skid #(
    parameter int unsigned       WIDTH       = 32,
    parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
    parameter int unsigned       CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    pipe_stage_skid_if.slave     bus,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e               state_q;
    logic [WIDTH-1:0]     main_q;
    logic [WIDTH-1:0]     skid_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q;
    logic [CNT_WIDTH-1:0] stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q;
    logic [CNT_WIDTH-1:0] flush_cnt_d;
    logic [CNT_WIDTH:0]   flush_sum;

    assign bus.out_valid = (state_q != EMPTY);
    assign bus.in_ready  = (state_q != FULL);
    assign bus.out_data  = main_q;
    assign occupancy     = state_q;
    assign stall_cnt     = stall_cnt_q;
    assign flush_cnt     = flush_cnt_q;

    // One bit of headroom catches the overflow so the add clamps to all-ones.
    assign flush_sum = {1'b0, flush_cnt_q} + (CNT_WIDTH+1)'(occupancy);

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.out_valid && !bus.out_ready && !flush && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;

        flush_cnt_d = flush_cnt_q;
        if (flush)
            flush_cnt_d = flush_sum[CNT_WIDTH] ? '1 : flush_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= RESET_VALUE;
            skid_q      <= RESET_VALUE;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            if (flush) begin
                state_q <= EMPTY;
                main_q  <= RESET_VALUE;
                skid_q  <= RESET_VALUE;
            end else begin
                unique case (state_q)
                    EMPTY: begin
                        if (bus.in_valid) begin
                            main_q  <= bus.in_data;
                            state_q <= BUSY;
                        end
                    end
                    BUSY: begin
                        if (bus.in_valid && bus.out_ready) begin
                            main_q <= bus.in_data;
                        end else if (bus.in_valid) begin
                            skid_q  <= bus.in_data;
                            state_q <= FULL;
                        end else if (bus.out_ready) begin
                            state_q <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (bus.out_ready) begin
                            main_q  <= skid_q;
                            state_q <= BUSY;
                        end
                    end
                    default: state_q <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid with WIDTH=8 and CNT_WIDTH=4, so counter saturation is reachable quickly.
module tb_pipe_stage_skid;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [1:0] occupancy;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;
    int         checks = 0;
    int         passes = 0;

    pipe_stage_skid_if #(.WIDTH(8)) bus ();

    pipe_stage_skid #(
        .WIDTH(8),
        .RESET_VALUE(8'h00),
        .CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .bus(bus),
        .occupancy(occupancy),
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    endtask

    // Load two beats with downstream stalled, leaving the stage FULL.
    task automatic fill_full(input logic [7:0] a, input logic [7:0] b);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = a;
        step();
        bus.in_data   = b;
        step();
        bus.in_valid  = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        chk("rst_occ",       32'(occupancy),     32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'h00);
        chk("rst_stall",     32'(stall_cnt),     32'd0);
        chk("rst_flush",     32'(flush_cnt),     32'd0);

        // Streaming at one beat per cycle
        bus.out_ready = 1'b1;
        for (int d = 1; d <= 4; d++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(d);
            step();
            chk("str_data",     32'(bus.out_data),  32'(d));
            chk("str_valid",    32'(bus.out_valid), 32'd1);
            chk("str_in_ready", 32'(bus.in_ready),  32'd1);
            chk("str_occ",      32'(occupancy),     32'd1);
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'hxx;
        step();
        chk("str_drain_occ", 32'(occupancy), 32'd0);
        chk("str_stall",     32'(stall_cnt), 32'd0);

        // Back-pressure: 10 accepted, then out_ready low for 3 cycles
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd10;
        step();
        bus.out_ready = 1'b0;
        bus.in_data   = 8'd11;
        step();
        chk("bp_in_ready_drop", 32'(bus.in_ready), 32'd0);
        bus.in_data = 8'd12;
        step();
        step();
        chk("bp_data_held", 32'(bus.out_data), 32'd10);
        chk("bp_occ",       32'(occupancy),    32'd2);
        chk("bp_in_ready",  32'(bus.in_ready), 32'd0);
        chk("bp_stall",     32'(stall_cnt),    32'd3);
        bus.out_ready = 1'b1;
        step();
        chk("bp_out11", 32'(bus.out_data), 32'd11);
        chk("bp_occ1",  32'(occupancy),    32'd1);
        step();
        chk("bp_out12", 32'(bus.out_data), 32'd12);
        chk("bp_occ1b", 32'(occupancy),    32'd1);
        bus.in_valid = 1'b0;
        step();
        chk("bp_empty",       32'(occupancy), 32'd0);
        chk("bp_stall_final", 32'(stall_cnt), 32'd3);

        // Flush while FULL with a concurrent upstream beat (stall 3 -> 4 while filling)
        fill_full(8'h20, 8'h21);
        chk("ff_occ_pre", 32'(occupancy), 32'd2);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        bus.out_ready = 1'b1;
        do_flush();
        chk("ff_occ",       32'(occupancy),     32'd0);
        chk("ff_out_valid", 32'(bus.out_valid), 32'd0);
        chk("ff_out_data",  32'(bus.out_data),  32'h00);
        chk("ff_flush_cnt", 32'(flush_cnt),     32'd2);
        chk("ff_stall",     32'(stall_cnt),     32'd4);
        bus.in_valid = 1'b0;
        step();
        chk("ff_no_aa", 32'(bus.out_data), 32'h00);
        chk("ff_occ2",  32'(occupancy),    32'd0);

        // Stall counter saturation: 4 + 20 clamps at 15
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h30;
        bus.out_ready = 1'b0;
        step();
        bus.in_valid = 1'b0;
        repeat (20) step();
        chk("sat_stall",      32'(stall_cnt),     32'd15);
        chk("sat_hold_data",  32'(bus.out_data),  32'h30);
        chk("sat_hold_valid", 32'(bus.out_valid), 32'd1);
        step();
        chk("sat_stall_stay", 32'(stall_cnt), 32'd15);

        // Flush counter: BUSY adds 1, EMPTY adds 0, FULL adds 2
        do_flush();
        chk("fc_busy", 32'(flush_cnt), 32'd3);
        do_flush();
        chk("fc_empty", 32'(flush_cnt), 32'd3);
        repeat (5) begin
            fill_full(8'h40, 8'h41);
            do_flush();
        end
        chk("fc_13", 32'(flush_cnt), 32'd13);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h50;
        step();
        bus.in_valid = 1'b0;
        do_flush();
        chk("fc_14", 32'(flush_cnt), 32'd14);
        fill_full(8'h60, 8'h61);
        do_flush();
        chk("fc_sat15", 32'(flush_cnt), 32'd15);

        // Reset and flush together while FULL: reset wins
        fill_full(8'h70, 8'h71);
        chk("rp_occ_pre", 32'(occupancy), 32'd2);
        rst_n = 1'b0;
        flush = 1'b1;
        step();
        chk("rp_occ",       32'(occupancy),     32'd0);
        chk("rp_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rp_flush_cnt", 32'(flush_cnt),     32'd0);
        chk("rp_stall_cnt", 32'(stall_cnt),     32'd0);
        rst_n = 1'b1;
        flush = 1'b0;
        step();
        chk("rp_flush_after", 32'(flush_cnt),    32'd0);
        chk("rp_in_ready",    32'(bus.in_ready), 32'd1);
        chk("rp_out_data",    32'(bus.out_data), 32'h00);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline-stage register for the segmented processor. It generalises the enable/clear stage register into a valid/ready handshake stage.
- A 2-entry skid buffer gives full throughput with a registered in_ready.
- Downstream stalls back-pressure upstream without combinational ready paths. Flush discards in-flight beats.
- Performance counters report stall cycles and flushed beats.

Parameters:
- WIDTH, 32, payload width in bits.
- RESET_VALUE, 0 (WIDTH bits), value loaded into data registers on reset and flush.
- CNT_WIDTH, 16, width of each saturating performance counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- flush  input  1  synchronous clear of stage contents (pipeline flush).
- in_valid  input  1  upstream beat present.
- in_ready  output  1  stage can accept a beat this cycle; driven from state register only.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  stage holds a beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  WIDTH  payload of the oldest held beat.
- occupancy  output  2  number of held beats, 0..2.
- stall_cnt  output  CNT_WIDTH  cycles with out_valid=1 and out_ready=0.
- flush_cnt  output  CNT_WIDTH  total beats discarded by flush.

Behaviour:
- One clock, clk. Reset is synchronous and active-low (rst_n); all state updates happen on the rising edge of clk.
- Storage is main_q (oldest beat, drives out_data) and skid_q.
- States:
  - EMPTY: occupancy 0.
  - BUSY: main_q valid, occupancy 1.
  - FULL: main_q and skid_q valid, occupancy 2.
- Outputs decode from state only:
  - out_valid = (state != EMPTY).
  - in_ready = (state != FULL).
  - out_data = main_q.
- Handshakes: upstream transfer = in_valid & in_ready; downstream transfer = out_valid & out_ready.
- Transitions (no reset, no flush):
  - EMPTY: in_valid -> main_q <= in_data, BUSY. Otherwise stay.
  - BUSY: in_valid & out_ready -> main_q <= in_data, stay BUSY.
  - BUSY: in_valid & !out_ready -> skid_q <= in_data, FULL.
  - BUSY: !in_valid & out_ready -> EMPTY; main_q keeps its value.
  - BUSY: otherwise hold.
  - FULL: out_ready -> main_q <= skid_q, BUSY. in_ready=0, so no input is taken.
  - FULL: !out_ready -> hold.
- Latency and throughput:
  - A beat accepted in cycle N is visible on out_data/out_valid in cycle N+1.
  - Sustained throughput is 1 beat/cycle when out_ready is held at 1.
  - Ordering is strictly FIFO.
- Data stability: while out_valid=1 and out_ready=0, out_data and out_valid do not change.
- Priority: reset, then flush, then normal operation.
- Reset (rst_n=0 at the edge):
  - state <= EMPTY.
  - main_q, skid_q <= RESET_VALUE.
  - stall_cnt, flush_cnt <= 0.
  - After reset: out_valid=0, in_ready=1, out_data=RESET_VALUE, occupancy=0.
  - Reset mid-transfer discards all held beats without counting them.
- Flush (rst_n=1, flush=1):
  - state <= EMPTY; main_q, skid_q <= RESET_VALUE.
  - Any same-cycle upstream or downstream handshake is void: the input beat is not stored and is not counted.
  - flush_cnt += occupancy before the flush (0, 1 or 2), saturating.
  - stall_cnt is unaffected by flush.
- stall_cnt:
  - Increments by 1 each cycle with out_valid=1 & out_ready=0 & flush=0.
  - Saturates at 2^CNT_WIDTH-1 with no wrap-around.
- flush_cnt saturates the same way. An add that would overflow clamps to all-ones.
- in_valid while in_ready=0 is ignored. Upstream must hold its beat, and the stage does not check this.
- X on in_data is allowed when in_valid=0 and must not reach main_q or skid_q.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then 1 -> out_valid=0, in_ready=1, occupancy=0, out_data=0, both counters 0.
- Streaming: out_ready=1, in_valid=1 with data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each. in_ready stays 1, occupancy stays 1, stall_cnt=0.
- Back-pressure:
  - Stimulus: stream data 10,11,12 with out_ready=0 from the cycle 10 is accepted, for 3 cycles.
  - Response: 11 goes to skid_q; in_ready drops to 0; 12 is held upstream; out_data stays 10; occupancy=2; stall_cnt=3.
  - Then raise out_ready: outputs 10,11,12 in order with no loss or duplicate.
- Flush when FULL: occupancy=2 and flush=1 with in_valid=1 (data 0xAA) -> next cycle occupancy=0, out_valid=0, out_data=RESET_VALUE, flush_cnt=2, 0xAA never appears.
- Saturation: CNT_WIDTH=4, hold out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt=15 and stays 15. Flush from FULL at flush_cnt=14 -> flush_cnt=15.
- Reset priority: rst_n=0 and flush=1 in the same cycle while FULL -> state EMPTY, flush_cnt stays 0 (reset wins).
